exec_stage: RTL
===============

// Module: exec_stage
// PURPOSE
//  Execute (E) stage; consumes the decode/execute pipeline register outputs.
//  Combinational ALU, destination-register select and zero flag for branches.
//  Iterative multiply/divide unit with HI/LO registers.
//  Stall request to the hazard logic while a dependent op waits on the unit.
// PARAMETERS
//  WIDTH     32  datapath width; HI/LO are WIDTH each
//  MD_CYCLES 32  iterations per MULT/DIV; must equal WIDTH
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  ALUControlE  in   3      010 add, 110 sub, 000 and, 001 or, 111 slt; others -> result 0
//  ALUSrcE      in   1      1: srcb = signimmE; 0: srcb = writedataE
//  RegDstE      in   1      1: writeregE = RdE; 0: writeregE = RtE
//  srcaE        in   32     operand A (also the MTHI/MTLO source)
//  writedataE   in   32     operand B register value
//  signimmE     in   32     sign-extended immediate
//  RtE,RdE      in   5      register specifiers
//  mdOpE        in   3      000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//  mdReadE      in   2      00 none, 01 MFHI, 10 MFLO (11 treated as 00)
//  aluoutE      out  32     ALU result, or HI/LO when mdReadE != 0
//  zeroE        out  1      aluoutE == 0
//  writeregE    out  5      destination register
//  md_stall     out  1      hold F/D/E and insert a bubble into M
//  hi,lo        out  32     architectural HI/LO
// BEHAVIOUR
//  - ALU, zeroE, writeregE: purely combinational, zero latency.
//    - add/sub wrap modulo 2^32.
//    - slt: signed compare giving 32'd1 or 32'd0.
//  - Reset: state=IDLE, hi=lo=0, iteration counter=0, md_stall=0.
//    - Reset mid-operation aborts the operation; HI/LO are not written.
//  - FSM states: IDLE, MUL, DIV. busy = (state != IDLE).
//  - Start: in IDLE with mdOpE in {MULT,MULTU,DIV,DIVU}:
//    - Operands are latched at that edge; state -> MUL or DIV; count=0.
//    - The issuing instruction continues down the pipe with no stall.
//  - Iteration: one bit per cycle for MD_CYCLES cycles.
//    - MUL: shift-add on magnitudes.
//    - DIV: restoring division on magnitudes.
//    - Signed ops: quotient/product sign = sa^sb; remainder sign = dividend sign.
//  - Completion:
//    - HI/LO are written on the edge ending the MD_CYCLES-th busy cycle; state -> IDLE.
//    - MUL: HI = product[63:32], LO = product[31:0].
//    - DIV: LO = quotient, HI = remainder.
//    - The next instruction reads the new values.
//  - Divide by zero: DIV goes IDLE->DIV->IDLE in 1 busy cycle; LO=32'hFFFFFFFF, HI=dividend.
//  - MTHI/MTLO: in IDLE, write srcaE to HI/LO at the edge; no busy state.
//  - md_stall = busy & (mdOpE != 000 | mdReadE != 00), combinational.
//    - While md_stall=1, the op held in E is not started or applied.
//    - The held op starts/applies in the first cycle md_stall=0.
//  - MFHI/MFLO when not stalled: aluoutE = current hi/lo.
//    - An MTHI in the same cycle is not visible until the next cycle.
//  - Non-MD instructions in E while busy: no stall, no effect on the unit.
// CONFIGURATION
//  EXEC_DIV_EN defined: DIV/DIVU supported as above.
//  EXEC_DIV_EN undefined:
//    - DIV state and divider datapath are omitted.
//    - mdOpE 011/100 are ignored: no state change, no stall, HI/LO unchanged.
// TESTING
//  - ALU: srca=7, writedata=9, ALUSrc=0, ALUControl=110 -> aluoutE=32'hFFFFFFFE, zeroE=0;
//    ALUControl=111 -> aluoutE=1.
//  - MULT: -3 x 5 issued, MFHI in E next cycle -> md_stall=1 for 32 cycles;
//    then aluoutE=32'hFFFFFFFF; MFLO gives 32'hFFFFFFF1.
//  - DIVU 100/7: after 32 cycles -> lo=14, hi=2.
//    DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
//  - DIV by 0, dividend=5: busy 1 cycle -> lo=32'hFFFFFFFF, hi=5, md_stall never asserted
//    for a non-MD follower.
//  - Reset at busy cycle 10 of a MULT, hi=lo=0x55 beforehand:
//    next cycle state IDLE, hi=lo=0, md_stall=0.
//  - Build without EXEC_DIV_EN: DIVU 100/7 -> hi/lo unchanged, md_stall stays 0.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage: execute stage with ALU, destination select and an iterative MULT/DIV unit with HI/LO.
// Define EXEC_DIV_EN to include DIV/DIVU; without it those opcodes are ignored.
module exec_stage #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       ALUControlE,
    input  logic             ALUSrcE,
    input  logic             RegDstE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] writedataE,
    input  logic [WIDTH-1:0] signimmE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       RdE,
    input  logic [2:0]       mdOpE,
    input  logic [1:0]       mdReadE,
    output logic [WIDTH-1:0] aluoutE,
    output logic             zeroE,
    output logic [4:0]       writeregE,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(MD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        MUL
`ifdef EXEC_DIV_EN
        , DIV
`endif
    } stateT;

    stateT            state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] accHi, accLo, opB, srcbE, aluRes, magA, magB, mulHi, mulLo;
    logic [WIDTH:0]   mulSum;
    logic [2*WIDTH-1:0] prodRes;
    logic             negRes, negA, negB, signedOp, isMult, mdReq, busy, lastIter;

    assign srcbE  = ALUSrcE ? signimmE : writedataE;
    assign aluRes = (ALUControlE == 3'b010) ? srcaE + srcbE :
                    (ALUControlE == 3'b110) ? srcaE - srcbE :
                    (ALUControlE == 3'b000) ? srcaE & srcbE :
                    (ALUControlE == 3'b001) ? srcaE | srcbE :
                    (ALUControlE == 3'b111) ? {{(WIDTH-1){1'b0}}, $signed(srcaE) < $signed(srcbE)} :
                    '0;
    assign aluoutE   = (mdReadE == 2'b01) ? hi : (mdReadE == 2'b10) ? lo : aluRes;
    assign zeroE     = (aluoutE == '0);
    assign writeregE = RegDstE ? RdE : RtE;

    assign isMult   = (mdOpE == 3'b001) || (mdOpE == 3'b010);
    assign signedOp = (mdOpE == 3'b001) || (mdOpE == 3'b011);
    assign negA     = signedOp & srcaE[WIDTH-1];
    assign negB     = signedOp & writedataE[WIDTH-1];
    assign magA     = negA ? -srcaE : srcaE;
    assign magB     = negB ? -writedataE : writedataE;
    assign busy     = (state != IDLE);
    assign lastIter = (count == CW'(MD_CYCLES - 1));
    assign md_stall = busy & mdReq;

    // Multiplier step: accHi accumulates, accLo shifts out multiplier bits and in product bits.
    assign mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    assign mulHi   = mulSum[WIDTH:1];
    assign mulLo   = {mulSum[0], accLo[WIDTH-1:1]};
    assign prodRes = negRes ? -{mulHi, mulLo} : {mulHi, mulLo};

`ifdef EXEC_DIV_EN
    logic             isDiv, negRem, divZero, divGe;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] divHi, divLo;

    assign isDiv = (mdOpE == 3'b011) || (mdOpE == 3'b100);
    assign mdReq = (mdOpE != 3'b000) || (mdReadE == 2'b01) || (mdReadE == 2'b10);
    // Restoring divider: accHi is the partial remainder, accLo shifts dividend out and quotient in.
    assign trial = {accHi, accLo[WIDTH-1]};
    assign divGe = (trial >= {1'b0, opB});
    assign divHi = divGe ? WIDTH'(trial - {1'b0, opB}) : trial[WIDTH-1:0];
    assign divLo = {accLo[WIDTH-2:0], divGe};
`else
    assign mdReq = (mdOpE != 3'b000 && mdOpE != 3'b011 && mdOpE != 3'b100) ||
                   (mdReadE == 2'b01) || (mdReadE == 2'b10);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            accHi  <= '0;
            accLo  <= '0;
            opB    <= '0;
            negRes <= 1'b0;
`ifdef EXEC_DIV_EN
            negRem  <= 1'b0;
            divZero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Operand registers track E while idle so they hold the issuing op's values at start.
                    count  <= '0;
                    accHi  <= '0;
                    accLo  <= magA;
                    opB    <= magB;
                    negRes <= negA ^ negB;
                    if (isMult) state <= MUL;
                    if (mdOpE == 3'b101) hi <= srcaE;
                    if (mdOpE == 3'b110) lo <= srcaE;
`ifdef EXEC_DIV_EN
                    negRem  <= negA;
                    divZero <= (writedataE == '0);
                    if (isDiv) state <= DIV;
                    if (isDiv && writedataE == '0) accLo <= srcaE;
`endif
                end
                MUL: begin
                    accHi <= mulHi;
                    accLo <= mulLo;
                    count <= count + 1'b1;
                    if (lastIter) begin
                        {hi, lo} <= prodRes;
                        state    <= IDLE;
                    end
                end
`ifdef EXEC_DIV_EN
                DIV: begin
                    if (divZero) begin
                        hi    <= accLo;
                        lo    <= '1;
                        state <= IDLE;
                    end else begin
                        accHi <= divHi;
                        accLo <= divLo;
                        count <= count + 1'b1;
                        if (lastIter) begin
                            hi    <= negRem ? -divHi : divHi;
                            lo    <= negRes ? -divLo : divLo;
                            state <= IDLE;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
